// File: rtl/router_pkg.sv
// Shared router definitions: byte/field widths, the destination reader
// state encoding, and header field extraction helpers.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_HDR,
    HDR_CAP,
    RD_BODY,
    CHECK
  } state_t;

  // Payload length lives in the upper six header bits.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] b);
    return b[DATA_W-1:ADDR_W];
  endfunction

  // Destination port lives in the low two header bits.
  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] b);
    return b[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity accumulator. Priority: clear, then load, then xor.
// Shared by the input-side parity generator and the destination reader.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         xor_en,
  input  logic [W-1:0] xor_val,
  output logic [W-1:0] acc
);

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn)     acc <= '0;
    else if (clear)  acc <= '0;
    else if (load)   acc <= load_val;
    else if (xor_en) acc <= acc ^ xor_val;
  end

endmodule

// File: rtl/router_dest_reader.sv
// Destination-side packet reader for one router output FIFO.
// Reads header, payload and parity byte; reports length, address and errors.
// Optional macro ROUTER_DEST_STATS_EN adds packet/error counters.
module router_dest_reader
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ADDR = 2'd0,
  parameter int         DELAY_W   = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid_out,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               soft_reset,
  input  logic [DELAY_W-1:0] start_delay,
  output logic               read_enb,
  output logic               pkt_done,
  output logic [LEN_W-1:0]   pkt_len,
  output logic [ADDR_W-1:0]  pkt_addr,
  output logic               parity_err,
  output logic               addr_err,
  output logic               busy
`ifdef ROUTER_DEST_STATS_EN
  ,
  output logic [15:0]        pkt_count,
  output logic [7:0]         err_count
`endif
);

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] dly_cnt;
  logic               rd_q;
  logic [LEN_W-1:0]   len_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [LEN_W:0]     remaining;   // reads still to issue (payload + parity)
  logic [LEN_W:0]     cap_cnt;     // body bytes captured so far
  logic [DATA_W-1:0]  par_byte;
  logic [DATA_W-1:0]  par_acc;
  logic               last_cap;
  logic               acc_clr, acc_load, acc_xor, do_check;
  logic               chk_perr, chk_aerr;

  // The last body capture is the parity byte, not payload.
  assign last_cap = rd_q && (cap_cnt == {1'b0, len_r});
  assign chk_perr = (par_acc != par_byte);
  assign chk_aerr = (addr_r != PORT_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; soft_reset aborts from any state.
  always_comb begin
    state_nxt = state;
    if (soft_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (valid_out) state_nxt = (start_delay != '0) ? WAIT : RD_HDR;
        WAIT:    if (dly_cnt == DELAY_W'(1)) state_nxt = RD_HDR;
        RD_HDR:  if (read_enb) state_nxt = HDR_CAP;
        HDR_CAP: state_nxt = RD_BODY;
        RD_BODY: if (last_cap) state_nxt = CHECK;
        CHECK:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs and datapath strobes decoded from state; read_enb drops the
  // same cycle as an underflow, abort or reset.
  always_comb begin
    read_enb = valid_out && !soft_reset && resetn &&
               ((state == RD_HDR) || ((state == RD_BODY) && (remaining != '0)));
    busy     = (state != IDLE);
    acc_clr  = (state == IDLE);
    acc_load = (state == HDR_CAP) && rd_q;
    acc_xor  = (state == RD_BODY) && rd_q && !last_cap;
    do_check = (state == CHECK) && !soft_reset;
  end

  // Delay, header, body bookkeeping and status registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dly_cnt    <= '0;
      rd_q       <= 1'b0;
      len_r      <= '0;
      addr_r     <= '0;
      remaining  <= '0;
      cap_cnt    <= '0;
      par_byte   <= '0;
      pkt_done   <= 1'b0;
      pkt_len    <= '0;
      pkt_addr   <= '0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      rd_q     <= read_enb;
      pkt_done <= do_check;
      case (state)
        IDLE: if (valid_out) dly_cnt <= start_delay;
        WAIT: dly_cnt <= dly_cnt - DELAY_W'(1);
        HDR_CAP: begin
          if (rd_q) begin
            len_r     <= hdr_len(data_in);
            addr_r    <= hdr_addr(data_in);
            remaining <= {1'b0, hdr_len(data_in)} + (LEN_W+1)'(1);
          end
          cap_cnt <= '0;
        end
        RD_BODY: begin
          if (read_enb) remaining <= remaining - (LEN_W+1)'(1);
          if (rd_q) begin
            cap_cnt <= cap_cnt + (LEN_W+1)'(1);
            if (last_cap) par_byte <= data_in;
          end
        end
        CHECK: begin
          if (do_check) begin
            pkt_len    <= len_r;
            pkt_addr   <= addr_r;
            parity_err <= chk_perr;
            addr_err   <= chk_aerr;
          end
        end
        default: ;
      endcase
    end
  end

  router_parity_acc #(.W(DATA_W)) u_par (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (acc_clr),
    .load     (acc_load),
    .load_val (data_in),
    .xor_en   (acc_xor),
    .xor_val  (data_in),
    .acc      (par_acc)
  );

`ifdef ROUTER_DEST_STATS_EN
  // Completed-packet and errored-packet counters; error count saturates.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (do_check) begin
      pkt_count <= pkt_count + 16'd1;
      if ((chk_perr || chk_aerr) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
